// File: rtl/spi_reg_sender_if.sv
// rtl/spi_reg_sender_if.sv - frame request handshake and SPI pin bundle for spi_reg_sender
//
// Groups the frame request side (i_valid/o_ready/i_data/i_len) together with
// the SPI pins and the status flags.
//   master : the requester (drives i_valid/i_data/i_len, watches everything else)
//   slave  : spi_reg_sender itself
// Members:
//   i_valid  frame request
//   o_ready  sender idle, request accepted when i_valid && o_ready
//   i_data   right-aligned payload, MAX_BITS wide
//   i_len    number of bits to send, LEN_W wide
//   o_csb    SPI chip select, active-low
//   o_sclk   SPI clock, idle low
//   o_mosi   SPI data
//   o_busy   frame in progress
//   o_done   one-cycle end-of-frame pulse
interface spi_reg_sender_if #(
  parameter int MAX_BITS = 32,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
);
  logic                i_valid;
  logic                o_ready;
  logic [MAX_BITS-1:0] i_data;
  logic [LEN_W-1:0]    i_len;
  logic                o_csb;
  logic                o_sclk;
  logic                o_mosi;
  logic                o_busy;
  logic                o_done;

  modport master (
    output i_valid, i_data, i_len,
    input  o_ready, o_csb, o_sclk, o_mosi, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_data, i_len,
    output o_ready, o_csb, o_sclk, o_mosi, o_busy, o_done
  );
endinterface

// File: rtl/spi_reg_sender.sv
// rtl/spi_reg_sender.sv - SPI mode-0 frame transmitter for loading raybox registers
//
// Accepts one right-aligned frame (data + bit count) at a time and shifts it
// out MSB-first on csb/sclk/mosi with an SCLK half-period of HALF clocks.
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        spi_reg_sender_if.slave: request handshake, SPI pins, busy/done
// All SPI pins and status flags are registers; o_ready decodes the state register.
module spi_reg_sender #(
  parameter int MAX_BITS = 32,
  parameter int HALF     = 2,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input logic             i_clk,
  input logic             i_reset_n,
  spi_reg_sender_if.slave bus
);

  localparam int               CW      = $clog2(HALF + 1);
  localparam logic [CW-1:0]    HALF_M1 = CW'(HALF - 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              state;
  logic [CW-1:0]       hcnt;
  logic [LEN_W-1:0]    bcnt;
  logic [MAX_BITS-1:0] shreg;
  logic                csb_q;
  logic                sclk_q;
  logic                mosi_q;
  logic                busy_q;
  logic                done_q;

  logic [LEN_W-1:0]    len_eff;
  logic [MAX_BITS-1:0] aligned;

  // Oversized lengths are clamped; the payload is then left-justified so the
  // first bit to send always sits at the top of the shift register.
  assign len_eff = (bus.i_len > MAX_LEN) ? MAX_LEN : bus.i_len;
  assign aligned = bus.i_data << (MAX_LEN - len_eff);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= S_IDLE;
      hcnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      csb_q  <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_valid) begin
            busy_q <= 1'b1;
            hcnt   <= HALF_M1;
            if (len_eff == '0) begin
              // Empty frame: keep the bus idle but still run the gap so the
              // caller gets its done pulse with normal timing.
              state <= S_GAP;
            end else begin
              state  <= S_SETUP;
              csb_q  <= 1'b0;
              shreg  <= aligned;
              bcnt   <= len_eff;
              mosi_q <= aligned[MAX_BITS-1];
            end
          end
        end

        default: begin
          if (hcnt != '0) begin
            hcnt <= hcnt - CW'(1);
          end else begin
            // Every state lasts HALF cycles, so the counter reloads on each entry.
            hcnt <= HALF_M1;
            case (state)
              S_SETUP: begin
                state  <= S_HIGH;
                sclk_q <= 1'b1;
              end
              S_HIGH: begin
                bcnt   <= bcnt - LEN_W'(1);
                sclk_q <= 1'b0;
                if (bcnt == LEN_W'(1)) begin
                  // Last bit already sampled; mosi keeps it through HOLD.
                  state <= S_HOLD;
                end else begin
                  // Next bit goes out on the same edge sclk falls.
                  state  <= S_LOW;
                  shreg  <= shreg << 1;
                  mosi_q <= shreg[MAX_BITS-2];
                end
              end
              S_LOW: begin
                state  <= S_HIGH;
                sclk_q <= 1'b1;
              end
              S_HOLD: begin
                state  <= S_GAP;
                csb_q  <= 1'b1;
                mosi_q <= 1'b0;
              end
              S_GAP: begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                shreg  <= '0;
                bcnt   <= '0;
              end
              default: begin
                // Unused encodings fall back to a clean idle bus.
                state  <= S_IDLE;
                csb_q  <= 1'b1;
                sclk_q <= 1'b0;
                mosi_q <= 1'b0;
                busy_q <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.o_ready = (state == S_IDLE);
  assign bus.o_csb   = csb_q;
  assign bus.o_sclk  = sclk_q;
  assign bus.o_mosi  = mosi_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_spi_reg_sender.sv
// tb/tb_spi_reg_sender.sv - directed self-checking bench for spi_reg_sender
module tb_spi_reg_sender;

  localparam int MAX_BITS = 32;
  localparam int HALF     = 2;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);
  localparam int LIMIT    = 500;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;

  spi_reg_sender_if #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) bus ();

  spi_reg_sender #(.MAX_BITS(MAX_BITS), .HALF(HALF), .LEN_W(LEN_W)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Mode-0 receiver model, sampled on the falling system clock edge.
  logic        prev_sclk = 1'b0;
  logic        prev_csb  = 1'b1;
  logic        prev_mosi = 1'b0;
  logic [63:0] rx_shift  = '0;
  int          rx_cnt    = 0;
  int          low_cnt   = 0;
  int          high_run  = 0;
  int          done_cnt  = 0;
  int          sclk_bad  = 0;
  int          mosi_bad  = 0;
  int          lat       = 0;
  int          last_lat  = -1;
  logic        lat_on    = 1'b0;
  int          q_cnt[$];
  logic [63:0] q_bits[$];
  int          q_low[$];
  int          q_gap[$];
  logic [5:0]  regs [16] = '{default: '0};

  always @(negedge i_clk) begin
    if (bus.o_done) done_cnt++;
    if (bus.o_sclk && !prev_sclk) begin
      if (!bus.o_csb) begin
        rx_shift = {rx_shift[62:0], bus.o_mosi};
        rx_cnt++;
      end else begin
        sclk_bad++;
      end
    end
    if (bus.o_sclk && prev_sclk && (bus.o_mosi != prev_mosi)) mosi_bad++;
    if (!bus.o_csb) low_cnt++;
    if (bus.o_csb) high_run++;
    if (!bus.o_csb && prev_csb) begin
      q_gap.push_back(high_run);
      high_run = 0;
    end
    if (lat_on) begin
      lat++;
      if (bus.o_ready) begin
        last_lat = lat;
        lat_on = 1'b0;
      end
    end
    if (bus.o_csb && !prev_csb) begin
      // Frame end (normal or aborted): record it and apply a register write.
      q_cnt.push_back(rx_cnt);
      q_bits.push_back(rx_shift);
      q_low.push_back(low_cnt);
      if (rx_cnt == 10) regs[rx_shift[9:6]] = rx_shift[5:0];
      rx_cnt = 0;
      rx_shift = '0;
      low_cnt = 0;
      high_run = 1;
      lat = 0;
      lat_on = 1'b1;
    end
    prev_sclk = bus.o_sclk;
    prev_csb  = bus.o_csb;
    prev_mosi = bus.o_mosi;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [LEN_W-1:0] len, input logic [MAX_BITS-1:0] data);
    int n;
    n = 0;
    @(negedge i_clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_len   = len;
    bus.i_data  = data;
    while (!bus.o_ready && n < LIMIT) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    chk({tag, "_accept_timeout"}, 64'(n >= LIMIT), 64'd0);
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      #1;
      n++;
    end while (!bus.o_done && n < LIMIT);
    chk({tag, "_done_timeout"}, 64'(n >= LIMIT), 64'd0);
    chk({tag, "_ready_with_done"}, 64'(bus.o_ready), 64'd1);
    repeat (2) @(negedge i_clk);
    #1;
  endtask

  initial begin
    int d0;
    int f0;
    int g0;
    int n;

    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_len   = '0;

    // Reset state
    repeat (3) @(negedge i_clk);
    #1;
    chk("reset_outputs", 64'({bus.o_csb, bus.o_sclk, bus.o_mosi, bus.o_busy, bus.o_done, bus.o_ready}),
        64'b100001);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // 8-bit 0xA5
    d0 = done_cnt;
    send("a5", 6'd8, 32'hA5);
    chk("a5_busy", 64'(bus.o_busy), 64'd1);
    wait_done("a5");
    chk("a5_edges", 64'(q_cnt[$]), 64'd8);
    chk("a5_bits", q_bits[$], 64'hA5);
    chk("a5_csb_low", 64'(q_low[$]), 64'd34);
    chk("a5_done_once", 64'(done_cnt - d0), 64'd1);
    chk("a5_ready_lat", 64'(last_lat), 64'd2);

    // 32-bit, first and last bit set
    send("w32", 6'd32, 32'h8000_0001);
    wait_done("w32");
    chk("w32_edges", 64'(q_cnt[$]), 64'd32);
    chk("w32_bits", q_bits[$], 64'h8000_0001);
    chk("w32_csb_low", 64'(q_low[$]), 64'd130);

    // Back-to-back with i_valid held: 0x9 then 0x6
    d0 = done_cnt;
    f0 = q_cnt.size();
    @(negedge i_clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_len   = 6'd4;
    bus.i_data  = 32'h9;
    @(posedge i_clk);
    #1;
    bus.i_data = 32'h6;
    n = 0;
    do begin
      @(negedge i_clk);
      #1;
      n++;
    end while (!bus.o_ready && n < LIMIT);
    chk("b2b_second_timeout", 64'(n >= LIMIT), 64'd0);
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    wait_done("b2b");
    chk("b2b_frames", 64'(q_cnt.size() - f0), 64'd2);
    chk("b2b_first", {q_bits[f0][59:0], 4'(q_cnt[f0])}, {60'h9, 4'd4});
    chk("b2b_second", {q_bits[f0+1][59:0], 4'(q_cnt[f0+1])}, {60'h6, 4'd4});
    chk("b2b_gap", 64'(q_gap[$]), 64'(HALF + 1));
    chk("b2b_done_twice", 64'(done_cnt - d0), 64'd2);

    // Zero-length frame
    d0 = done_cnt;
    f0 = q_cnt.size();
    g0 = q_gap.size();
    send("zero", 6'd0, 32'hFFFF_FFFF);
    wait_done("zero");
    chk("zero_no_frame", 64'(q_cnt.size() - f0), 64'd0);
    chk("zero_no_csb_fall", 64'(q_gap.size() - g0), 64'd0);
    chk("zero_done_once", 64'(done_cnt - d0), 64'd1);

    // Oversized length clamps to MAX_BITS
    send("clamp", 6'd40, 32'hFFFF_FFFF);
    wait_done("clamp");
    chk("clamp_edges", 64'(q_cnt[$]), 64'd32);
    chk("clamp_bits", q_bits[$], 64'hFFFF_FFFF);

    // Reset after the third rising edge of a 16-bit frame
    send("abort", 6'd16, 32'hABCD);
    n = 0;
    while (rx_cnt < 3 && n < LIMIT) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    chk("abort_edge_timeout", 64'(n >= LIMIT), 64'd0);
    chk("abort_sclk_high_before", 64'(bus.o_sclk), 64'd1);
    i_reset_n = 1'b0;
    #1;
    chk("abort_outputs", 64'({bus.o_csb, bus.o_sclk, bus.o_mosi, bus.o_busy, bus.o_done, bus.o_ready}),
        64'b100001);
    repeat (3) @(negedge i_clk);
    #1;
    chk("abort_partial_frame", {q_bits[$][59:0], 4'(q_cnt[$])}, {60'b101, 4'd3});
    i_reset_n = 1'b1;
    @(negedge i_clk);
    #1;
    chk("abort_ready_after", 64'(bus.o_ready), 64'd1);
    send("post", 6'd8, 32'h3C);
    wait_done("post");
    chk("post_frame", {q_bits[$][59:0], 4'(q_cnt[$])}, {60'h3C, 4'd8});

    // Loopback register write: command 1, value 0x2A
    send("loop", 6'd10, {22'd0, 4'h1, 6'h2A});
    wait_done("loop");
    chk("loop_reg1", 64'(regs[1]), 64'h2A);
    chk("loop_reg0_untouched", 64'(regs[0]), 64'h0);

    chk("sclk_while_csb_high", 64'(sclk_bad), 64'd0);
    chk("mosi_while_sclk_high", 64'(mosi_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
